// File: rtl/riscv_fetch_req_ctrl.sv
// Instruction fetch request engine: issues word reads on the instr bus
// (req/gnt/rvalid), keeps one transaction in flight, pushes returned words
// into the fetch FIFO and handles branch / hardware-loop redirects.
module riscv_fetch_req_ctrl #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i,
    input  logic        hwlp_jump_i,
    input  logic [31:0] hwlp_target_i,
    input  logic        fifo_ready_i,
    output logic        fifo_clear_o,
    output logic        fifo_valid_o,
    output logic [31:0] fifo_addr_o,
    output logic [31:0] fifo_rdata_o,
    output logic        fifo_replace2_o,
    output logic        fifo_is_hwlp_o,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    output logic        busy_o
);

    typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RVALID, WAIT_ABORTED} state_t;

    state_t      r_state;
    logic [31:0] r_fetch_addr;   // next address to fetch (bit1 kept after redirect)
    logic        r_fetch_hwlp;   // next fetch is the first word of a hwlp target
    logic [31:0] r_bus_addr;     // request held on the bus while waiting for gnt
    logic        r_bus_hwlp;
    logic        r_abort;        // redirect arrived while waiting for gnt
    logic [31:0] r_infl_addr;    // address reported with the in-flight word
    logic        r_infl_hwlp;
    logic        r_started;      // no fetching until the first redirect

    logic        w_redir;
    logic [31:0] w_tgt;
    logic        w_tgt_hwlp;
    logic [31:0] w_naddr;
    logic        w_nhwlp;
    logic        w_slot;
    logic        w_issue;
    logic        w_push;

    // Redirect target (branch wins) and the address the next new request uses
    assign w_redir    = branch_i | hwlp_jump_i;
    assign w_tgt      = branch_i ? branch_addr_i : hwlp_target_i;
    assign w_tgt_hwlp = ~branch_i & hwlp_jump_i;
    assign w_naddr    = w_redir ? w_tgt : r_fetch_addr;
    assign w_nhwlp    = w_redir ? w_tgt_hwlp : r_fetch_hwlp;

    // A new request may start when the bus is free or frees up this cycle
    assign w_slot  = (r_state == IDLE) |
                     (((r_state == WAIT_RVALID) | (r_state == WAIT_ABORTED)) & instr_rvalid_i);
    assign w_issue = w_slot & req_i & fifo_ready_i & (r_started | w_redir);
    // A word returning in a redirect cycle belongs to the old stream
    assign w_push  = (r_state == WAIT_RVALID) & instr_rvalid_i & ~w_redir;

    assign fifo_clear_o    = branch_i;
    assign fifo_valid_o    = w_push;
    assign fifo_addr_o     = w_push ? r_infl_addr : 32'h0;
    assign fifo_rdata_o    = instr_rdata_i;
    assign fifo_replace2_o = w_push & r_infl_hwlp;
    assign fifo_is_hwlp_o  = w_push & r_infl_hwlp;
    assign instr_req_o     = (r_state == WAIT_GNT) | w_issue;
    assign instr_addr_o    = (r_state == WAIT_GNT) ? (r_bus_addr & ~32'h3) :
                             w_issue               ? (w_naddr & ~32'h3)    : 32'h0;
    assign busy_o          = (r_state != IDLE);

    // Transaction FSM, fetch pointer and in-flight bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_fetch_addr <= RESET_ADDR;
            r_fetch_hwlp <= 1'b0;
            r_bus_addr   <= 32'h0;
            r_bus_hwlp   <= 1'b0;
            r_abort      <= 1'b0;
            r_infl_addr  <= 32'h0;
            r_infl_hwlp  <= 1'b0;
            r_started    <= 1'b0;
        end else begin
            if (w_redir) begin
                r_started    <= 1'b1;
                r_fetch_addr <= w_tgt;
                r_fetch_hwlp <= w_tgt_hwlp;
            end
            if (w_issue) begin
                if (instr_gnt_i) begin
                    r_state      <= WAIT_RVALID;
                    r_infl_addr  <= w_naddr & ~32'h1;
                    r_infl_hwlp  <= w_nhwlp;
                    r_fetch_addr <= (w_naddr & ~32'h3) + 32'd4;
                    r_fetch_hwlp <= 1'b0;
                end else begin
                    r_state      <= WAIT_GNT;
                    r_bus_addr   <= w_naddr & ~32'h1;
                    r_bus_hwlp   <= w_nhwlp;
                    r_abort      <= 1'b0;
                    r_fetch_addr <= w_naddr;
                    r_fetch_hwlp <= w_nhwlp;
                end
            end else begin
                case (r_state)
                    WAIT_GNT: begin
                        if (w_redir) r_abort <= 1'b1;
                        if (instr_gnt_i) begin
                            if (r_abort | w_redir) begin
                                r_state <= WAIT_ABORTED;
                            end else begin
                                r_state      <= WAIT_RVALID;
                                r_infl_addr  <= r_bus_addr;
                                r_infl_hwlp  <= r_bus_hwlp;
                                r_fetch_addr <= (r_bus_addr & ~32'h3) + 32'd4;
                                r_fetch_hwlp <= 1'b0;
                            end
                        end
                    end
                    WAIT_RVALID: begin
                        if (instr_rvalid_i)  r_state <= IDLE;
                        else if (w_redir)    r_state <= WAIT_ABORTED;
                    end
                    WAIT_ABORTED: begin
                        if (instr_rvalid_i)  r_state <= IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
